// File: rtl/hilo_div_sequencer_pkg.sv
// Shared MIPS definitions for the HI/LO divide path: FSM encoding, function
// codes and the ALUop values the control decoder drives into this block.
package hilo_div_sequencer_pkg;

  localparam int HILO_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

  // R-type function codes (opcode SPECIAL).
  localparam logic [5:0] FUNCT_MFHI = 6'h10;
  localparam logic [5:0] FUNCT_MFLO = 6'h12;
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU = 6'h1B;

  // ALUop values the decoder emits for the instructions this block serves.
  localparam logic [3:0] ALUOP_DIV  = 4'hA;
  localparam logic [3:0] ALUOP_MFLO = 4'hB;
  localparam logic [3:0] ALUOP_MFHI = 4'hC;

  function automatic logic funct_is_div(input logic [5:0] funct);
    return (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
  endfunction

  function automatic logic funct_is_hilo_rd(input logic [5:0] funct);
    return (funct == FUNCT_MFHI) || (funct == FUNCT_MFLO);
  endfunction

  function automatic logic aluop_is_hilo_rd(input logic [3:0] aluop);
    return (aluop == ALUOP_MFHI) || (aluop == ALUOP_MFLO);
  endfunction

endpackage

// File: rtl/hilo_div_sequencer_div_restore_step.sv
// One restoring-divide iteration: shift remainder:quotient left, trial
// subtract, keep the difference only when it did not go negative.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           neg;

  // rem_i < div_i, so the shifted value is below 2*div_i and the extra top
  // bit of the difference is a reliable borrow flag.
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, div_i};
  assign neg     = diff[WIDTH];

  assign rem_o = neg ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~neg};

endmodule

// File: rtl/hilo_div_sequencer.sv
// DIV/DIVU sequencer owning HI/LO: magnitude restoring divide, one bit per
// cycle, sign fixup in a final cycle, and pipeline stall generation.
module hilo_div_sequencer
  import hilo_div_sequencer_pkg::*;
#(
  parameter int WIDTH = HILO_W,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             hilo_rd,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output div_state_e       dbg_state
);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] raw_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             dz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] dvd_mag_d;
  logic [WIDTH-1:0] dvs_mag_d;
  logic             dvd_neg;
  logic             dvs_neg;

  assign dvd_neg   = div_signed & dividend[WIDTH-1];
  assign dvs_neg   = div_signed & divisor[WIDTH-1];
  assign dvd_mag_d = dvd_neg ? -dividend : dividend;
  assign dvs_mag_d = dvs_neg ? -divisor : divisor;

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .div_i(dvs_q),
    .rem_o(rem_d),
    .quo_o(quo_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      raw_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      if (flush) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (div_start) begin
              rem_q   <= '0;
              quo_q   <= dvd_mag_d;
              dvs_q   <= dvs_mag_d;
              raw_q   <= dividend;
              qneg_q  <= dvd_neg ^ dvs_neg;
              rneg_q  <= dvd_neg;
              dz_q    <= (divisor == '0);
              cnt_q   <= '0;
              state_q <= ST_ITER;
            end
          end
          ST_ITER: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_q <= ST_FIX;
            end
          end
          ST_FIX: begin
            // A zero divisor reports the raw rs value in HI, unsigned-style.
            if (dz_q) begin
              lo_q <= '1;
              hi_q <= raw_q;
            end else begin
              lo_q <= qneg_q ? -quo_q : quo_q;
              hi_q <= rneg_q ? -rem_q : rem_q;
            end
            done_q  <= 1'b1;
            dbz_q   <= dz_q;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Pipeline handshake: while busy, any HI/LO reader or new divide in EX is
  // held (stall=1); the held instruction proceeds in the first cycle busy=0,
  // which is also the cycle done pulses with the fresh HI/LO.
  assign busy        = (state_q != ST_IDLE);
  assign stall       = busy & (hilo_rd | div_start);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_hilo_div_sequencer.sv
// Directed bench for hilo_div_sequencer: a cycle-count/arithmetic model is
// compared against the DUT on every falling edge, plus literal result checks.
module tb_hilo_div_sequencer;
  import hilo_div_sequencer_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         div_start;
  logic         div_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         hilo_rd;
  logic         flush;
  logic         busy;
  logic         stall;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  div_state_e   dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  hilo_div_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .div_start(div_start), .div_signed(div_signed),
    .dividend(dividend), .divisor(divisor), .hilo_rd(hilo_rd), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  // Result per MIPS arithmetic: truncating division, remainder takes the
  // dividend's sign; divide by zero gives lo=all ones, hi=raw dividend.
  function automatic logic [2*W:0] model_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    longint sa, sb, q, r;
    if (b == '0) return {1'b1, a, {W{1'b1}}};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[W-1:0], q[W-1:0]};
  endfunction

  int           m_left;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         m_done, m_dz, p_dz;

  // A divide occupies WIDTH+1 edges after the accepting edge; results land
  // on the last of them and done shows in the following cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_dz <= 1'b0;
      p_hi <= '0; p_lo <= '0; p_dz <= 1'b0;
    end else if (flush) begin
      m_left <= 0; m_done <= 1'b0; m_dz <= 1'b0;
    end else if (m_left == 0) begin
      m_done <= 1'b0; m_dz <= 1'b0;
      if (div_start) begin
        m_left <= W + 1;
        {p_dz, p_hi, p_lo} <= model_div(dividend, divisor, div_signed);
      end
    end else if (m_left == 1) begin
      m_left <= 0; m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1; m_dz <= p_dz;
    end else begin
      m_left <= m_left - 1;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", W'(busy), W'(m_left != 0));
      chk("stall", W'(stall), W'((m_left != 0) && (hilo_rd || div_start)));
      chk("done", W'(done), W'(m_done));
      chk("div_by_zero", W'(div_by_zero), W'(m_dz));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    dividend = a; divisor = b; div_signed = s; div_start = 1'b1;
    step();
    div_start = 1'b0;
  endtask

  // Waits for the done cycle (positioned at its falling edge); counts busy cycles.
  task automatic wait_done(input string name, output int busy_cycles);
    bit found = 0;
    busy_cycles = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1;
      else if (busy) busy_cycles++;
    end
    if (!found) begin
      n_assert++; n_fail++;
      $display("FAIL %s_timeout: done not seen within 100 cycles", name);
    end
  endtask

  // ---------------- stimulus ----------------
  int bc;
  initial begin
    rst_n = 1'b0; div_start = 1'b0; div_signed = 1'b0; dividend = '0;
    divisor = '0; hilo_rd = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    chk("reset_hi", hi, '0);
    chk("reset_lo", lo, '0);

    // DIVU 100/7
    step();
    issue(32'd100, 32'd7, 1'b0);
    wait_done("divu_100_7", bc);
    chk("divu_busy_cycles", W'(bc), 32'd33);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    chk("divu_dz", W'(div_by_zero), '0);
    chk("model_lo_100_7", m_lo, 32'd14);
    chk("model_hi_100_7", m_hi, 32'd2);

    // DIV -7/2
    step();
    issue(32'hFFFF_FFF9, 32'h2, 1'b1);
    wait_done("div_m7_2", bc);
    chk("div_m7_lo", lo, 32'hFFFF_FFFD);
    chk("div_m7_hi", hi, 32'hFFFF_FFFF);
    chk("model_lo_m7_2", m_lo, 32'hFFFF_FFFD);

    // Signed overflow
    step();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("div_ovf", bc);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0);
    chk("div_ovf_dz", W'(div_by_zero), '0);

    // Divide by zero, unsigned and signed negative
    step();
    issue(32'd5, 32'd0, 1'b0);
    wait_done("divu_5_0", bc);
    chk("dz_busy_cycles", W'(bc), 32'd33);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_hi", hi, 32'd5);
    chk("dz_flag", W'(div_by_zero), 32'd1);
    step();
    issue(32'hFFFF_FFFB, 32'd0, 1'b1);
    wait_done("div_m5_0", bc);
    chk("dz_s_hi", hi, 32'hFFFF_FFFB);
    chk("dz_s_lo", lo, 32'hFFFF_FFFF);

    // MFLO held from cycle 3
    step();
    issue(32'd100, 32'd7, 1'b0);
    step(); step();
    hilo_rd = 1'b1;
    @(negedge clk);
    chk("stall_rd_high", W'(stall), 32'd1);
    wait_done("stall_rd", bc);
    chk("stall_rd_done_stall", W'(stall), '0);
    chk("stall_rd_lo", lo, 32'd14);
    step();
    hilo_rd = 1'b0;

    // Second DIV held from cycle 3; accepted only in the done cycle
    issue(32'd100, 32'd7, 1'b0);
    step(); step();
    dividend = 32'd50; divisor = 32'd5; div_signed = 1'b0; div_start = 1'b1;
    @(negedge clk);
    chk("stall_div_high", W'(stall), 32'd1);
    wait_done("stall_div_first", bc);
    chk("stall_div_first_lo", lo, 32'd14);
    chk("stall_div_done_stall", W'(stall), '0);
    step();
    div_start = 1'b0;
    @(negedge clk);
    chk("second_div_busy", W'(busy), 32'd1);
    wait_done("stall_div_second", bc);
    chk("second_div_lo", lo, 32'd10);
    chk("second_div_hi", hi, 32'd0);

    // Preload hi=lo=0x1234, then flush a 9/3 at cycle 10
    step();
    issue(32'h0246_9234, 32'h2000, 1'b0);
    wait_done("preload", bc);
    chk("preload_lo", lo, 32'h1234);
    chk("preload_hi", hi, 32'h1234);
    step();
    issue(32'd9, 32'd3, 1'b0);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", W'(busy), '0);
    bc = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) bc++;
    end
    chk("flush_no_done", W'(bc), '0);
    chk("flush_lo", lo, 32'h1234);
    chk("flush_hi", hi, 32'h1234);

    // Asynchronous reset mid-ITER
    step();
    issue(32'd77, 32'd3, 1'b0);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", W'(busy), '0);
    chk("arst_hi", hi, '0);
    chk("arst_lo", lo, '0);
    step();
    rst_n = 1'b1;
    step();
    issue(32'd8, 32'd2, 1'b0);
    wait_done("post_reset", bc);
    chk("post_reset_lo", lo, 32'd4);
    chk("post_reset_hi", hi, 32'd0);

    step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_div_sequencer.md
Name: hilo_div_sequencer

Overview:
- Multi-cycle controller for the DIV/DIVU path and the HI/LO register pair in the MIPS pipeline.
- Accepts a divide issued from EX and runs a restoring divide, one quotient bit per cycle.
- Owns HI/LO, and stalls the pipeline while a divide is in flight if MFHI/MFLO or a second DIV reaches EX.
- Sits beside the ALU. The control decoder's DIV/MFLO/MFHI ALUop decode drives its start and read-request inputs.

Parameters:
WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.
CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
div_start  in  1  DIV/DIVU valid in EX this cycle
div_signed  in  1  1 = DIV (signed), 0 = DIVU
dividend  in  WIDTH  rs operand
divisor  in  WIDTH  rt operand
hilo_rd  in  1  MFHI or MFLO valid in EX this cycle
flush  in  1  pipeline flush; abort in-flight divide
busy  out  1  divide in progress (state != IDLE)
stall  out  1  hold IF/ID/EX; combinational = busy & (hilo_rd | div_start)
done  out  1  one-cycle pulse, HI/LO just updated
div_by_zero  out  1  one-cycle pulse with done when divisor was 0
hi  out  WIDTH  HI register (remainder)
lo  out  WIDTH  LO register (quotient)

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE, counter=0.
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0.
  - Reset during ITER/FIX discards the operation.
- States: IDLE, ITER, FIX.
- IDLE:
  - On div_start & !flush, latch the following at the edge and go to ITER:
    - |dividend| and |divisor| (absolute values only when div_signed).
    - Quotient sign = sign(dividend) XOR sign(divisor).
    - Remainder sign = sign(dividend).
    - A zero-divisor flag.
  - Clear the counter on entry.
- ITER:
  - Each edge: shift remainder:quotient left by 1, trial-subtract the divisor from the remainder, restore if negative, set the quotient LSB to 1 if not negative.
  - Counter increments every edge. After WIDTH edges (counter==WIDTH-1 at the edge), go to FIX.
- FIX, at the edge:
  - Apply sign fixup: negate the quotient if its sign flag is set; negate the remainder if the dividend was negative.
  - Write lo=quotient, hi=remainder. Register done=1 for the following cycle. Go to IDLE.
- Latency:
  - Start sampled at edge E0; HI/LO valid after edge E(WIDTH+1), i.e. E33 for WIDTH=32.
  - busy is high in the cycles between E0 and E33.
- Stall:
  - hilo_rd or a new div_start while busy asserts stall. The pipeline holds the instruction.
  - In the cycle after FIX, busy=0, so a held MFLO reads the new lo and a held DIV starts.
  - div_start in the same cycle as done is accepted normally.
- Divide by zero:
  - Full latency still applies.
  - Result is forced to lo = all ones, hi = original dividend (raw rs value), with no sign fixup. div_by_zero pulses with done.
- Signed overflow: 0x80000000 / -1 gives lo=0x80000000, hi=0 (falls out of the magnitude path), with no flag.
- flush:
  - Any state goes to IDLE at the next edge. hi/lo are unchanged and no done is produced.
  - flush beats div_start in the same cycle.
- hi/lo change only in FIX and on reset.

Decomposition:
- Shared MIPS definitions header:
  - State encoding constants (IDLE/ITER/FIX).
  - DIV/DIVU/MFHI/MFLO function codes and the DIV/MFLO/MFHI ALUop values, reused by the decoder and this block.
- One natural sub-module: div_restore_step. It is a combinational single-bit step: inputs rem, quo, divisor; outputs next rem and quo.

Test Plan:
- DIVU 100/7 → busy for 33 cycles, done pulse, lo=14, hi=2, div_by_zero=0.
- DIV -7/2 (0xFFFFFFF9, 0x2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 5/0 → after 33 cycles lo=0xFFFFFFFF, hi=5, div_by_zero and done pulse together.
- DIVU 100/7 then hilo_rd held from cycle 3 → stall=1 until the done cycle, then stall=0 and lo reads 14. Repeat with a second div_start: it is accepted only in the done cycle.
- Start DIVU 9/3 with hi=lo=0x1234 preloaded by a prior divide, flush at cycle 10 → busy=0 next cycle, no done, hi/lo stay 0x1234.
- Drop rst_n asynchronously mid-ITER → busy, hi, lo go 0 immediately. After release, a new DIVU 8/2 gives lo=4, hi=0.
